// File: rtl/quad_encoder_decoder.sv
// rtl/quad_encoder_decoder.sv - 4x quadrature decoder with index capture and phase error tracking
module quad_encoder_decoder #(
   parameter int CNT_W = 32,
   parameter int ERR_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enc_a,
   input  logic                    enc_b,
   input  logic                    enc_z,
   input  logic                    cnt_en,
   input  logic                    dir_invert,
   input  logic                    z_clr_en,
   input  logic                    clr,
   input  logic                    err_clr,
   output logic signed [CNT_W-1:0] position,
   output logic                    dir,
   output logic                    step_pulse,
   output logic                    z_pulse,
   output logic        [CNT_W-1:0] z_latch,
   output logic                    phase_err,
   output logic        [ERR_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

   logic [1:0]       r_ab_q;
   logic             r_z_q;
   logic [CNT_W-1:0] r_position;
   logic             r_dir;
   logic             r_step_pulse;
   logic             r_z_pulse;
   logic [CNT_W-1:0] r_z_latch;
   logic             r_phase_err;
   logic [ERR_W-1:0] r_err_cnt;

   logic [1:0] w_ab;
   logic       w_fwd_raw;
   logic       w_rev_raw;
   logic       w_step;
   logic       w_fwd;
   logic       w_illegal;
   logic       w_z_rise;

   assign w_ab = {enc_a, enc_b};

   // Gray-code transitions: A leads B in the forward direction
   always_comb begin
      w_fwd_raw = 1'b0;
      w_rev_raw = 1'b0;
      case ({r_ab_q, w_ab})
         4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd_raw = 1'b1;
         4'b0001, 4'b0111, 4'b1110, 4'b1000: w_rev_raw = 1'b1;
         default: ;
      endcase
   end

   assign w_step    = w_fwd_raw | w_rev_raw;
   assign w_fwd     = dir_invert ? w_rev_raw : w_fwd_raw;
   assign w_illegal = ((r_ab_q ^ w_ab) == 2'b11);
   assign w_z_rise  = enc_z & ~r_z_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ab_q       <= w_ab;
         r_z_q        <= enc_z;
         r_position   <= '0;
         r_dir        <= 1'b0;
         r_step_pulse <= 1'b0;
         r_z_pulse    <= 1'b0;
         r_z_latch    <= '0;
         r_phase_err  <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         r_ab_q       <= w_ab;
         r_z_q        <= enc_z;
         r_step_pulse <= w_step & cnt_en;
         r_z_pulse    <= w_z_rise;

         if (w_step)
            r_dir <= w_fwd;

         if (w_z_rise)
            r_z_latch <= r_position;

         if (clr)
            r_position <= '0;
         else if (w_z_rise && z_clr_en)
            r_position <= '0;
         else if (w_step && cnt_en)
            r_position <= w_fwd ? r_position + CNT_ONE : r_position - CNT_ONE;

         // A fresh error in the clearing cycle restarts the count at one
         if (w_illegal) begin
            r_phase_err <= 1'b1;
            if (err_clr)
               r_err_cnt <= ERR_ONE;
            else if (!(&r_err_cnt))
               r_err_cnt <= r_err_cnt + ERR_ONE;
         end else if (err_clr) begin
            r_phase_err <= 1'b0;
            r_err_cnt   <= '0;
         end
      end
   end

   assign position   = r_position;
   assign dir        = r_dir;
   assign step_pulse = r_step_pulse;
   assign z_pulse    = r_z_pulse;
   assign z_latch    = r_z_latch;
   assign phase_err  = r_phase_err;
   assign err_cnt    = r_err_cnt;

endmodule

// File: doc/quad_encoder_decoder.md
Name: quad_encoder_decoder

Overview:
- Downstream of the per-channel encoder glitch filters: consumes the filtered A, B and Z lines and performs 4x quadrature decoding into a signed position count.
- Also reports direction, per-step strobes, index (Z) events with position capture, and illegal-transition (phase error) detection.
- All inputs are already synchronous to clk because the filters register them, so no extra synchronisers are required.

Parameters:
- CNT_W, 32, position and Z-latch width in bits; position is two's-complement.
- ERR_W, 16, error counter width in bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enc_a  input  1  filtered encoder phase A
- enc_b  input  1  filtered encoder phase B
- enc_z  input  1  filtered encoder index
- cnt_en  input  1  1 = position counting enabled
- dir_invert  input  1  1 = swap forward/reverse sense
- z_clr_en  input  1  1 = rising edge of Z clears position
- clr  input  1  synchronous software clear of position
- err_clr  input  1  clears phase_err and err_cnt
- position  output  CNT_W  signed position count
- dir  output  1  last valid step direction (1 = forward)
- step_pulse  output  1  one-cycle strobe per counted step
- z_pulse  output  1  one-cycle strobe on Z rising edge
- z_latch  output  CNT_W  position captured at last Z rising edge
- phase_err  output  1  sticky illegal-transition flag
- err_cnt  output  ERR_W  saturating count of illegal transitions

Behaviour:

History registers:
- ab_q holds the previous {enc_a, enc_b}; z_q holds the previous enc_z.
- During reset, ab_q and z_q load the live inputs, so releasing reset causes no spurious step or Z event.

Reset values:
- position, z_latch, err_cnt are 0.
- dir, step_pulse, z_pulse, phase_err are 0.

Decode (compares the current {enc_a, enc_b} with ab_q every cycle):
- Forward sequence is 00→10→11→01→00 (A leads B).
- Reverse sequence is 00→01→11→10→00.
- No change: no action.
- Both bits change in one cycle (00↔11, 10↔01): illegal transition.
  - No step is counted.
  - phase_err is set to 1.
  - err_cnt increments, saturating at all-ones.
- dir_invert=1 swaps the forward/reverse classification before any use.

Step (legal transition):
- dir is set to the step direction, regardless of cnt_en.
- If cnt_en=1: position is incremented (forward) or decremented (reverse), and step_pulse=1 for exactly one cycle.
- If cnt_en=0: position holds and step_pulse stays 0.
- Latency: the input change is sampled at clock edge N; position, dir and step_pulse are valid after edge N.

Wrap-around:
- Position wraps modulo 2^CNT_W with no saturation (0x7FFF_FFFF + 1 = 0x8000_0000; 0 − 1 = 0xFFFF_FFFF).

Z index:
- A rising edge is detected when enc_z=1 and z_q=0.
- On a rising edge: z_pulse=1 for one cycle, and z_latch captures the position register value from before that edge's update.
- If z_clr_en=1, position loads 0 on the same edge. The clear overrides any simultaneous step; step_pulse still asserts if cnt_en=1.
- A falling edge of Z has no effect.

Priority for the position register (highest first):
- reset
- clr (loads 0; z_latch and the error state are unaffected)
- Z-clear
- step
- hold

Error clearing:
- err_clr clears phase_err and err_cnt.
- If an illegal transition occurs in the same cycle as err_clr: phase_err=1 and err_cnt=1 (the new error wins).

Reset mid-operation:
- All outputs return to their reset values on the next edge.
- History registers resynchronise to the live inputs.

Test Plan:
- Reset with A=1, B=1, Z=1, then release → position=0, step_pulse=0, z_pulse=0 for 5 cycles.
- 8 forward transitions (00→10→11→01→00→…), cnt_en=1 → position=8, dir=1, eight step_pulse strobes; then 3 reverse transitions → position=5, dir=0.
- Preload to 0xFFFF_FFFF via 1 reverse step from 0, then 2 forward steps → position=1; with dir_invert=1, the same forward sequence decrements.
- Position=37, Z rising edge with z_clr_en=1 coinciding with a forward step → z_latch=37, position=0, z_pulse=1 for one cycle; repeat with z_clr_en=0 → position=1 more than before the edge, z_latch=pre-edge value.
- Jump 00→11 three times → phase_err=1, err_cnt=3, position unchanged; err_clr together with a fourth illegal jump → err_cnt=1, phase_err=1.
- cnt_en=0 during 4 forward steps → position held, step_pulse=0, dir=1; clr asserted together with a step → position=0.
